// File: rtl/jtdd_sndcmd.sv
// -----------------------------------------------------------------------------
// jtdd_sndcmd
//
// Command path from the main CPU to the sound CPU. The main CPU writes command
// bytes into a small circular FIFO. A four-state sequencer (IDLE, LOAD, IRQ,
// GAP) presents one byte at a time on snd_latch and raises snd_irq until the
// sound CPU acknowledges the byte or a timeout expires. After each command,
// snd_irq stays low for GAP cen cycles so that back-to-back commands show up
// as distinct interrupt edges.
//
// Parameters
//   AW    FIFO address width; the FIFO depth is 2**AW bytes
//   TOUT  cen cycles snd_irq may stay high without an acknowledge
//   GAP   cen cycles snd_irq is held low between two commands
//
// Ports
//   clk        system clock (the only clock)
//   rst        asynchronous active-high reset
//   cen        main-CPU clock enable; qualifies every state change except
//              the acknowledge capture
//   cmd_we     main-CPU write strobe, sampled when cen=1
//   cmd_din    command byte to queue
//   snd_ack    one-clk pulse: the sound CPU has read snd_latch
//   snd_latch  command byte presented to the sound CPU (registered)
//   snd_irq    level interrupt request to the sound CPU (registered)
//   full       FIFO holds 2**AW entries
//   busy       FIFO non-empty or sequencer not IDLE
//   ovf        sticky: a write was dropped because the FIFO was full
//   tout       sticky: a command timed out without an acknowledge
// -----------------------------------------------------------------------------
module jtdd_sndcmd #(
  parameter int AW   = 2,
  parameter int TOUT = 4095,
  parameter int GAP  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       tout
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int DEPTH = 1 << AW;

  // The timer has to reach TOUT while in IRQ and GAP-1 while in GAP; it is
  // sized for the larger of the two and never counts past its terminal value.
  localparam int TMAX = (TOUT > (GAP - 1)) ? TOUT : (GAP - 1);
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO_C = {(AW + 1){1'b0}};
  localparam logic [TW-1:0] TOUT_C     = TW'(TOUT);
  localparam logic [TW-1:0] GAP_LAST_C = TW'(GAP - 1);
  localparam logic [TW-1:0] TMR_ZERO_C = {TW{1'b0}};

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_IRQ  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_r [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nxt_s;

  logic          ack_pend_r;
  logic          consume_s;
  logic          tout_hit_s;
  logic          enter_load_s;

  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake decode
  // ---------------------------------------------------------------------------
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == CNT_ZERO_C);

  // The head is consumed exactly when LOAD is left. LOAD is only ever entered
  // with count>0 and nothing else decrements the count, so the FIFO cannot be
  // empty here.
  assign pop_s = cen & (state_r == ST_LOAD);

  // A write into a full FIFO is still accepted when the same cen cycle pops
  // the head: the slot freed by the pop is reused, so the count stays put.
  assign push_s = cen & cmd_we & (~full_s | pop_s);
  assign drop_s = cen & cmd_we & full_s & ~pop_s;

  assign enter_load_s = cen & (state_r == ST_IDLE) & ~empty_s;

  assign full = full_s;
  assign busy = ~empty_s | (state_r != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer next-state and timer logic
  // ---------------------------------------------------------------------------
  // Next state, next timer value and the one-cycle consume/timeout strobes
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    consume_s   = 1'b0;
    tout_hit_s  = 1'b0;
    if (cen) begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_nxt_s = ST_IRQ;
          timer_nxt_s = TMR_ZERO_C;
        end
        ST_IRQ: begin
          if (ack_pend_r) begin
            state_nxt_s = ST_GAP;
            timer_nxt_s = TMR_ZERO_C;
            consume_s   = 1'b1;
          end else if (timer_r == TOUT_C) begin
            // Give up on this command; the GAP count restarts from zero so
            // the low time is the same as after a normal acknowledge.
            state_nxt_s = ST_GAP;
            timer_nxt_s = TMR_ZERO_C;
            tout_hit_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IRQ;
            timer_nxt_s = timer_r + TW'(1);
          end
        end
        ST_GAP: begin
          if (timer_r == GAP_LAST_C) begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = timer_r;
          end else begin
            state_nxt_s = ST_GAP;
            timer_nxt_s = timer_r + TW'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          timer_nxt_s = TMR_ZERO_C;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
    end
  end

  // Sequencer state and timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Acknowledge capture
  // ---------------------------------------------------------------------------
  // snd_ack is a single clk pulse that may fall on a cen=0 cycle, so it is
  // held until the sequencer can use it. Clearing on LOAD entry discards any
  // acknowledge that arrived outside IRQ, so a stray pulse can never retire
  // the next command early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pend_r <= 1'b0;
    end else if (enter_load_s) begin
      ack_pend_r <= 1'b0;
    end else if (snd_ack) begin
      ack_pend_r <= 1'b1;
    end else if (consume_s) begin
      ack_pend_r <= 1'b0;
    end else begin
      ack_pend_r <= ack_pend_r;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Byte storage; no reset needed since only slots covered by count are read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_din;
    end
  end

  // Write and read pointers, wrapping naturally modulo the depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO_C;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs to the sound CPU
  // ---------------------------------------------------------------------------
  // Latch the FIFO head when leaving LOAD; held through IRQ, GAP and IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_latch <= 8'h00;
    end else if (pop_s) begin
      snd_latch <= mem_r[rd_ptr_r];
    end else begin
      snd_latch <= snd_latch;
    end
  end

  // Interrupt request, registered from the next state so it is high exactly
  // while the sequencer sits in IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_irq <= 1'b0;
    end else if (cen) begin
      snd_irq <= (state_nxt_s == ST_IRQ);
    end else begin
      snd_irq <= snd_irq;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by reset
  // ---------------------------------------------------------------------------
  // Overflow: a write was discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop_s) begin
      ovf <= 1'b1;
    end else begin
      ovf <= ovf;
    end
  end

  // Timeout: a command was retired without an acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout <= 1'b0;
    end else if (tout_hit_s) begin
      tout <= 1'b1;
    end else begin
      tout <= tout;
    end
  end

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// -----------------------------------------------------------------------------
// tb_jtdd_sndcmd
//
// Directed bench for jtdd_sndcmd (AW=2, TOUT=15, GAP=8). Inputs change and
// outputs are sampled 1 ns after each rising clock edge. All expected values
// are hand-derived cycle counts and constants.
// -----------------------------------------------------------------------------
module tb_jtdd_sndcmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       cmd_we;
  logic [7:0] cmd_din;
  logic       snd_ack;
  logic [7:0] snd_latch;
  logic       snd_irq;
  logic       full;
  logic       busy;
  logic       ovf;
  logic       tout;

  int n_cmp = 0;
  int n_err = 0;
  bit half_rate = 1'b0;

  // 100 MHz clock
  always #5 clk = ~clk;

  jtdd_sndcmd #(
    .AW   (2),
    .TOUT (15),
    .GAP  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .cmd_we    (cmd_we),
    .cmd_din   (cmd_din),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .full      (full),
    .busy      (busy),
    .ovf       (ovf),
    .tout      (tout)
  );

  // Advance n clock edges; cen toggles per edge in half-rate mode
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (half_rate) cen = ~cen;
      else           cen = 1'b1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_we    = 1'b0;
    cmd_din   = 8'h00;
    snd_ack   = 1'b0;
    half_rate = 1'b0;
    cen       = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // One write, accepted on the next edge (when cen=1 there)
  task automatic push(input logic [7:0] d);
    cmd_din = d;
    cmd_we  = 1'b1;
    tick(1);
    cmd_we  = 1'b0;
  endtask

  // Ack the current command; the next one is presented 11 edges later
  // (GAP x8, IDLE, LOAD, IRQ)
  task automatic ack_and_next(input logic [7:0] d);
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    tick(10);
    check_val("next_irq_low", {31'd0, snd_irq}, 32'd0);
    tick(1);
    check_val("next_irq_high", {31'd0, snd_irq}, 32'd1);
    check_val("next_latch", {24'd0, snd_latch}, {24'd0, d});
  endtask

  // Global bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; cen = 1'b1; cmd_we = 1'b0; cmd_din = 8'h00; snd_ack = 1'b0;
    tick(2);
    check_val("rst_latch", {24'd0, snd_latch}, 32'h00);
    check_val("rst_irq",   {31'd0, snd_irq}, 32'd0);
    check_val("rst_full",  {31'd0, full}, 32'd0);
    check_val("rst_busy",  {31'd0, busy}, 32'd0);
    check_val("rst_ovf",   {31'd0, ovf}, 32'd0);
    check_val("rst_tout",  {31'd0, tout}, 32'd0);
    rst = 1'b0;

    // ---------------- single command with ack ----------------
    push(8'h5A);
    check_val("c1_irq_e0", {31'd0, snd_irq}, 32'd0);
    check_val("c1_busy_e0", {31'd0, busy}, 32'd1);
    tick(1);
    check_val("c1_irq_e1", {31'd0, snd_irq}, 32'd0);
    tick(1);
    check_val("c1_irq_e2", {31'd0, snd_irq}, 32'd1);
    check_val("c1_latch", {24'd0, snd_latch}, 32'h5A);
    tick(9);
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    check_val("c1_irq_at_ack", {31'd0, snd_irq}, 32'd1);
    tick(1);
    check_val("c1_irq_after_ack", {31'd0, snd_irq}, 32'd0);
    check_val("c1_busy_gap", {31'd0, busy}, 32'd1);
    tick(7);
    check_val("c1_busy_gap_end", {31'd0, busy}, 32'd1);
    tick(1);
    check_val("c1_busy_idle", {31'd0, busy}, 32'd0);
    check_val("c1_latch_hold", {24'd0, snd_latch}, 32'h5A);

    // Stray ack while IDLE must not retire the next command
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    push(8'h33);
    tick(2);
    check_val("stray_irq_rise", {31'd0, snd_irq}, 32'd1);
    check_val("stray_latch", {24'd0, snd_latch}, 32'h33);
    tick(2);
    check_val("stray_irq_held", {31'd0, snd_irq}, 32'd1);

    // ---------------- fill FIFO, overflow, ordered delivery ----------------
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check_val("fill_latch", {24'd0, snd_latch}, 32'h01);
    check_val("fill_irq",   {31'd0, snd_irq}, 32'd1);
    check_val("fill_full",  {31'd0, full}, 32'd1);
    check_val("fill_ovf",   {31'd0, ovf}, 32'd0);
    push(8'h06);
    check_val("ovf_set",    {31'd0, ovf}, 32'd1);
    check_val("ovf_full",   {31'd0, full}, 32'd1);
    for (int i = 2; i <= 5; i++) ack_and_next(8'(i));
    check_val("drain_full", {31'd0, full}, 32'd0);
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    tick(9);
    check_val("drain_busy", {31'd0, busy}, 32'd0);
    check_val("drain_latch", {24'd0, snd_latch}, 32'h05);
    check_val("drain_ovf_sticky", {31'd0, ovf}, 32'd1);

    // ---------------- write when full during LOAD pop ----------------
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    tick(10);
    push(8'hAA);
    check_val("ld_full",  {31'd0, full}, 32'd1);
    check_val("ld_ovf",   {31'd0, ovf}, 32'd0);
    check_val("ld_latch", {24'd0, snd_latch}, 32'h02);
    ack_and_next(8'h03);
    ack_and_next(8'h04);
    ack_and_next(8'h05);
    ack_and_next(8'hAA);
    check_val("ld_ovf_end", {31'd0, ovf}, 32'd0);

    // ---------------- timeout ----------------
    do_reset();
    push(8'h77);
    tick(2);
    check_val("to_irq_rise", {31'd0, snd_irq}, 32'd1);
    push(8'h88);
    tick(14);
    check_val("to_irq_last", {31'd0, snd_irq}, 32'd1);
    check_val("to_tout_pre", {31'd0, tout}, 32'd0);
    tick(1);
    check_val("to_irq_fall", {31'd0, snd_irq}, 32'd0);
    check_val("to_tout_set", {31'd0, tout}, 32'd1);
    check_val("to_latch", {24'd0, snd_latch}, 32'h77);
    tick(9);
    check_val("to_gap_low", {31'd0, snd_irq}, 32'd0);
    tick(1);
    check_val("to_next_irq", {31'd0, snd_irq}, 32'd1);
    check_val("to_next_latch", {24'd0, snd_latch}, 32'h88);

    // ---------------- half-rate cen, ack on a cen=0 cycle ----------------
    do_reset();
    half_rate = 1'b1;
    cen = 1'b1;
    push(8'h9C);
    tick(3);
    check_val("hr_irq_pre", {31'd0, snd_irq}, 32'd0);
    tick(1);
    check_val("hr_irq_rise", {31'd0, snd_irq}, 32'd1);
    check_val("hr_latch", {24'd0, snd_latch}, 32'h9C);
    snd_ack = 1'b1;
    tick(1);
    snd_ack = 1'b0;
    check_val("hr_irq_cen0", {31'd0, snd_irq}, 32'd1);
    tick(1);
    check_val("hr_irq_fall", {31'd0, snd_irq}, 32'd0);
    half_rate = 1'b0;
    cen = 1'b1;

    // ---------------- reset during IRQ with 3 queued ----------------
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check_val("mr_irq", {31'd0, snd_irq}, 32'd1);
    check_val("mr_latch_pre", {24'd0, snd_latch}, 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check_val("mr_irq_async",   {31'd0, snd_irq}, 32'd0);
    check_val("mr_busy_async",  {31'd0, busy}, 32'd0);
    check_val("mr_latch_async", {24'd0, snd_latch}, 32'h00);
    check_val("mr_full_async",  {31'd0, full}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);
    check_val("mr_queue_empty", {31'd0, busy}, 32'd0);
    check_val("mr_irq_quiet",   {31'd0, snd_irq}, 32'd0);
    push(8'h44);
    tick(1);
    check_val("mr_first_e1", {31'd0, snd_irq}, 32'd0);
    tick(1);
    check_val("mr_first_e2", {31'd0, snd_irq}, 32'd1);
    check_val("mr_first_latch", {24'd0, snd_latch}, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtdd_sndcmd.md
JTDD_SNDCMD -- requirements
Module: jtdd_sndcmd

Interface
REQ-001 Parameter AW, default 2, FIFO depth = 2**AW command bytes.
REQ-002 Parameter TOUT, default 4095, cen cycles snd_irq may stay high without acknowledge.
REQ-003 Parameter GAP, default 8, cen cycles snd_irq is held low between two commands.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cen  in  1  main-CPU clock enable; qualifies all state changes except ack capture.
REQ-007 cmd_we  in  1  main-CPU write strobe to the sound command port, sampled when cen=1.
REQ-008 cmd_din  in  8  command byte.
REQ-009 snd_ack  in  1  one-clk pulse: sound CPU has read snd_latch.
REQ-010 snd_latch  out  8  command byte presented to the sound CPU.
REQ-011 snd_irq  out  1  interrupt request to the sound CPU, level.
REQ-012 full  out  1  FIFO holds 2**AW entries.
REQ-013 busy  out  1  FIFO non-empty or state not IDLE.
REQ-014 ovf  out  1  sticky: a write was dropped.
REQ-015 tout  out  1  sticky: a command timed out unacknowledged.

Function
REQ-016 FIFO: circular, AW-bit read/write pointers plus (AW+1)-bit count; pointers wrap modulo 2**AW.
REQ-017 Push: cen=1 and cmd_we=1 and (count<2**AW or pop in same cycle) -> store cmd_din, count+1 (net 0 with simultaneous pop).
REQ-018 Push when full with no same-cycle pop: byte discarded, FIFO unchanged, ovf set to 1.
REQ-019 ack capture: snd_ack=1 on any clk sets ack_pend; ack_pend cleared when consumed on a cen cycle or on entering LOAD.
REQ-020 States IDLE, LOAD, IRQ, GAP; transitions only on cen=1.
REQ-021 IDLE: count>0 -> LOAD; else stay.
REQ-022 LOAD: snd_latch <= FIFO head, pop (count-1, read pointer+1), timer <= 0 -> IRQ.
REQ-023 IRQ: snd_irq=1; ack_pend=1 -> GAP, timer <= 0, consume ack; else timer=TOUT -> GAP, tout set to 1; else timer+1.
REQ-024 GAP: snd_irq=0; timer=GAP-1 -> IDLE; else timer+1.
REQ-025 snd_irq registered, high exactly while state=IRQ; rises one cen after LOAD.
REQ-026 snd_latch changes only in LOAD; holds value through IRQ, GAP and IDLE.
REQ-027 Latency: write into empty FIFO while IDLE -> snd_irq high 3 cen cycles later (push, LOAD, IRQ).
REQ-028 snd_ack outside IRQ state is ignored and does not survive into the next command.
REQ-029 Timer width ceil(log2(TOUT+1)) bits, no wrap beyond TOUT.
REQ-030 full and busy combinational from registered state; ovf and tout clear only on reset.

Reset
REQ-031 rst=1 asynchronously: state IDLE, pointers/count/timer 0, ack_pend 0, snd_latch 8'h00, snd_irq 0, full 0, busy 0, ovf 0, tout 0.
REQ-032 rst asserted mid-IRQ drops snd_irq immediately and discards all queued commands.
REQ-033 First command after reset release follows REQ-027 timing.

Verification
REQ-034 cen=1 always; write 8'h5A, ack 10 cycles after snd_irq rises -> snd_latch=5A, snd_irq high 3 cycles after write, low 1 cycle after ack, busy low after GAP.
REQ-035 Write 5 bytes 01..05 back-to-back with AW=2, sound side stalled -> bytes 01 in latch, 02..05 queued, full=1, ovf=0; 6th write -> ovf=1, later delivered order 01..05.
REQ-036 No ack, TOUT=15 -> snd_irq high 16 cen cycles, then tout=1, next command follows after GAP.
REQ-037 Write when full simultaneous with LOAD pop -> byte accepted, count stays 4, ovf=0.
REQ-038 cen at 1/2 rate, snd_ack pulse on cen=0 cycle during IRQ -> captured, snd_irq falls on next cen.
REQ-039 rst pulse during IRQ with 3 queued -> snd_irq=0, busy=0, snd_latch=00 same cycle; queue empty.
